// File: rtl/ddr3_pg_transfer_engine.sv
// ddr3_pg_transfer_engine
//
// Responder end of the DDR3 page-transfer handshake. It accepts one page
// request at a time and moves one page between the shared page DPRAM and DDR3
// through the MIG user interface. Runs in the DDR3 ui clock domain.
//
// Ports:
//   clk, rst             ui clock, synchronous active-high reset
//   pg_req/pg_ack        four-phase request/acknowledge with the page mux
//   pg_optype            1 = DPRAM -> DDR3 (write), 0 = DDR3 -> DPRAM (read)
//   pg_req_addr          page start address in app_addr units
//   dpram_*              page DPRAM port (read data has 1-cycle latency)
//   init_calib_complete  MIG calibration done; requests wait for it
//   app_*                MIG user interface (command, write data, read data)
module ddr3_pg_transfer_engine #(
  parameter int unsigned P_PG_BEATS  = 128,
  parameter int unsigned P_ADDR_STEP = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          pg_req,
  input  logic                          pg_optype,
  input  logic [27:0]                   pg_req_addr,
  output logic                          pg_ack,
  output logic [$clog2(P_PG_BEATS)-1:0] dpram_addr,
  input  logic [127:0]                  dpram_dout,
  output logic [127:0]                  dpram_din,
  output logic                          dpram_wren,
  input  logic                          init_calib_complete,
  output logic [27:0]                   app_addr,
  output logic [2:0]                    app_cmd,
  output logic                          app_en,
  input  logic                          app_rdy,
  output logic [127:0]                  app_wdf_data,
  output logic                          app_wdf_wren,
  output logic                          app_wdf_end,
  output logic [15:0]                   app_wdf_mask,
  input  logic                          app_wdf_rdy,
  input  logic [127:0]                  app_rd_data,
  input  logic                          app_rd_data_valid
);

  localparam int unsigned AW   = $clog2(P_PG_BEATS);
  localparam int unsigned CntW = AW + 1;

  localparam logic [CntW-1:0] BeatsCnt = CntW'(P_PG_BEATS);
  localparam logic [CntW-1:0] LastCnt  = CntW'(P_PG_BEATS - 1);
  localparam logic [27:0]     AddrStep = 28'(P_ADDR_STEP);

  localparam logic [2:0] CmdWrite = 3'b000;
  localparam logic [2:0] CmdRead  = 3'b001;

  typedef enum logic [2:0] {
    StIdle,
    StWrFetch,
    StWrIssue,
    StRd,
    StAck
  } state_t;

  state_t state_q, state_d;

  logic [27:0]     app_addr_q;
  logic [CntW-1:0] cmd_cnt_q;   // write beats accepted / read commands issued
  logic [CntW-1:0] ret_cnt_q;   // read beats returned
  logic [AW-1:0]   dpram_addr_q;
  logic [127:0]    dpram_din_q;
  logic            dpram_wren_q;

  logic accept;
  logic wr_accept;
  logic rd_cmd;
  logic rd_ret;

  assign accept    = (state_q == StIdle) && pg_req && init_calib_complete;
  // Command and data are only ever accepted together in the same cycle.
  assign wr_accept = (state_q == StWrIssue) && app_rdy && app_wdf_rdy;
  assign rd_cmd    = (state_q == StRd) && app_en && app_rdy;
  // Returns outside StRd (e.g. late data after a reset) are dropped.
  assign rd_ret    = (state_q == StRd) && app_rd_data_valid;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          state_d = pg_optype ? StWrFetch : StRd;
        end
      end
      StWrFetch: state_d = StWrIssue;
      StWrIssue: begin
        if (wr_accept) begin
          state_d = (cmd_cnt_q == LastCnt) ? StAck : StWrFetch;
        end
      end
      StRd: begin
        if (rd_ret && (ret_cnt_q == LastCnt)) begin
          state_d = StAck;
        end
      end
      StAck: begin
        if (!pg_req) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // Output logic
  always_comb begin
    pg_ack       = 1'b0;
    app_en       = 1'b0;
    app_wdf_wren = 1'b0;
    app_cmd      = CmdWrite;
    unique case (state_q)
      StWrIssue: begin
        // Cross-coupled so neither half of a beat is taken without the other.
        app_en       = app_wdf_rdy;
        app_wdf_wren = app_rdy;
      end
      StRd: begin
        app_cmd = CmdRead;
        app_en  = (cmd_cnt_q < BeatsCnt);
      end
      StAck: pg_ack = 1'b1;
      default: ;
    endcase
  end

  assign app_wdf_end  = app_wdf_wren;
  assign app_wdf_data = dpram_dout;
  assign app_wdf_mask = 16'h0000;
  assign app_addr     = app_addr_q;
  assign dpram_addr   = dpram_addr_q;
  assign dpram_din    = dpram_din_q;
  assign dpram_wren   = dpram_wren_q;

  // Datapath: addresses, counters and DPRAM write port
  always_ff @(posedge clk) begin
    if (rst) begin
      app_addr_q   <= '0;
      cmd_cnt_q    <= '0;
      ret_cnt_q    <= '0;
      dpram_addr_q <= '0;
      dpram_din_q  <= '0;
      dpram_wren_q <= 1'b0;
    end else begin
      dpram_wren_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (accept) begin
            app_addr_q   <= pg_req_addr;
            cmd_cnt_q    <= '0;
            ret_cnt_q    <= '0;
            dpram_addr_q <= '0;
          end
        end
        StWrIssue: begin
          if (wr_accept) begin
            cmd_cnt_q <= cmd_cnt_q + CntW'(1);
            if (cmd_cnt_q != LastCnt) begin
              app_addr_q   <= app_addr_q + AddrStep;
              dpram_addr_q <= dpram_addr_q + AW'(1);
            end
          end
        end
        StRd: begin
          if (rd_cmd) begin
            cmd_cnt_q  <= cmd_cnt_q + CntW'(1);
            app_addr_q <= app_addr_q + AddrStep;
          end
          // MIG returns in order, so the return count is the DPRAM word index.
          if (rd_ret) begin
            dpram_din_q  <= app_rd_data;
            dpram_wren_q <= 1'b1;
            dpram_addr_q <= ret_cnt_q[AW-1:0];
            ret_cnt_q    <= ret_cnt_q + CntW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ddr3_pg_transfer_engine.sv
// Directed bench for ddr3_pg_transfer_engine with a DPRAM model and a small
// in-order MIG model (20-cycle read latency, optional ready stalls).
module tb_ddr3_pg_transfer_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         pg_req;
  logic         pg_optype;
  logic [27:0]  pg_req_addr;
  logic         pg_ack;
  logic [6:0]   dpram_addr;
  logic [127:0] dpram_dout = '0;
  logic [127:0] dpram_din;
  logic         dpram_wren;
  logic         init_calib_complete;
  logic [27:0]  app_addr;
  logic [2:0]   app_cmd;
  logic         app_en;
  logic         app_rdy = 1'b1;
  logic [127:0] app_wdf_data;
  logic         app_wdf_wren;
  logic         app_wdf_end;
  logic [15:0]  app_wdf_mask;
  logic         app_wdf_rdy = 1'b1;
  logic [127:0] app_rd_data = '0;
  logic         app_rd_data_valid = 1'b0;

  always #5 clk = ~clk;

  ddr3_pg_transfer_engine #(
    .P_PG_BEATS (128),
    .P_ADDR_STEP(8)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .pg_req             (pg_req),
    .pg_optype          (pg_optype),
    .pg_req_addr        (pg_req_addr),
    .pg_ack             (pg_ack),
    .dpram_addr         (dpram_addr),
    .dpram_dout         (dpram_dout),
    .dpram_din          (dpram_din),
    .dpram_wren         (dpram_wren),
    .init_calib_complete(init_calib_complete),
    .app_addr           (app_addr),
    .app_cmd            (app_cmd),
    .app_en             (app_en),
    .app_rdy            (app_rdy),
    .app_wdf_data       (app_wdf_data),
    .app_wdf_wren       (app_wdf_wren),
    .app_wdf_end        (app_wdf_end),
    .app_wdf_mask       (app_wdf_mask),
    .app_wdf_rdy        (app_wdf_rdy),
    .app_rd_data        (app_rd_data),
    .app_rd_data_valid  (app_rd_data_valid)
  );

  int n_checks = 0;
  int n_errors = 0;

  // Monitor-owned state (written only by the posedge monitor)
  int           cyc = 0;
  int           acc_cnt = 0;
  int           viol = 0;
  int           wren_cnt = 0;
  int           en_cnt = 0;
  int           ack_cnt = 0;
  logic [27:0]  wq_addr[$];
  logic [127:0] wq_data[$];
  logic [27:0]  rq_addr[$];
  int           rq_t[$];
  logic [127:0] mem[128];

  // MIG-model-owned state
  int ret_ptr = 0;

  // Stimulus-owned knobs: 0 always ready, 1 scripted write stalls, 2 random app_rdy
  int mode = 0;
  int wr_base = 0;

  function automatic logic [127:0] rd_pat(input int g);
    return {32'(g), ~32'(g), 32'hA5A5_5A5A, 32'(g * 3 + 1)};
  endfunction

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Posedge monitor: samples pre-edge values; also models the DPRAM.
  initial begin
    for (int k = 0; k < 128; k++) mem[k] = 128'(k);
    forever begin
      @(posedge clk);
      cyc++;
      if (!rst) begin
        if (app_en && app_rdy && app_cmd == 3'b000) begin
          if (!(app_wdf_wren && app_wdf_rdy)) viol++;
          wq_addr.push_back(app_addr);
          wq_data.push_back(app_wdf_data);
          acc_cnt++;
        end else if (app_wdf_wren && app_wdf_rdy) begin
          viol++;
        end
        if (app_wdf_end !== app_wdf_wren) viol++;
        if (app_wdf_mask !== 16'h0) viol++;
        if (app_en && app_rdy && app_cmd == 3'b001) begin
          rq_addr.push_back(app_addr);
          rq_t.push_back(cyc);
        end
      end
      if (dpram_wren) begin
        mem[dpram_addr] = dpram_din;
        wren_cnt++;
      end
      dpram_dout <= mem[dpram_addr];
      if (app_en) en_cnt++;
      if (pg_ack) ack_cnt++;
    end
  end

  // MIG model: ready generation and in-order read returns.
  initial begin
    int b;
    int last_b = -1;
    int stall_cyc = 0;
    logic wstall, rstall;
    forever begin
      @(negedge clk);
      if (mode == 1) begin
        b = acc_cnt - wr_base;
        if (b != last_b) begin
          stall_cyc = 0;
          last_b = b;
        end
        wstall = (b >= 3 && b <= 5) && stall_cyc < 3;
        rstall = (b == 10) && stall_cyc < 3;
        app_wdf_rdy = !wstall;
        app_rdy = !rstall;
        if (wstall || rstall) stall_cyc++;
      end else if (mode == 2) begin
        app_wdf_rdy = 1'b1;
        app_rdy = ($urandom_range(0, 3) != 0);
      end else begin
        app_wdf_rdy = 1'b1;
        app_rdy = 1'b1;
      end
      if (ret_ptr < rq_t.size() && cyc >= rq_t[ret_ptr] + 20 && $urandom_range(0, 3) != 0) begin
        app_rd_data_valid = 1'b1;
        app_rd_data = rd_pat(ret_ptr);
        ret_ptr++;
      end else begin
        app_rd_data_valid = 1'b0;
        app_rd_data = '0;
      end
    end
  end

  task automatic wait_ack(input int limit, output int at);
    int n = 0;
    at = -1;
    while (pg_ack !== 1'b1 && n < limit) begin
      @(negedge clk);
      n++;
    end
    if (pg_ack === 1'b1) at = cyc;
    else check("ack_timeout", 0, 1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pg_ack"}, pg_ack, 0);
    check({tag, "_app_en"}, app_en, 0);
    check({tag, "_wdf_wren"}, app_wdf_wren, 0);
    check({tag, "_wdf_end"}, app_wdf_end, 0);
    check({tag, "_dpram_wren"}, dpram_wren, 0);
    check({tag, "_dpram_addr"}, dpram_addr, 0);
    check({tag, "_app_addr"}, app_addr, 0);
    check({tag, "_app_cmd"}, app_cmd, 0);
    check({tag, "_dpram_din"}, dpram_din, 0);
  endtask

  task automatic check_writes(input string tag, input int wb, input logic [27:0] base);
    int bad = 0;
    check({tag, "_beats"}, wq_addr.size() - wb, 128);
    if (wq_addr.size() - wb == 128) begin
      check({tag, "_first_addr"}, wq_addr[wb], base);
      check({tag, "_last_data"}, wq_data[wb + 127], 128'd127);
      for (int k = 0; k < 128; k++) begin
        if (wq_addr[wb + k] !== 28'(base + 28'(8 * k)) || wq_data[wb + k] !== 128'(k)) bad++;
      end
      check({tag, "_order"}, bad, 0);
    end
  endtask

  // Called at the ack negedge of a read; drops pg_req and checks the page.
  task automatic finish_read(input string tag, input int rb, input int wb,
                             input logic [27:0] base);
    int bad = 0;
    check({tag, "_ack_wren"}, dpram_wren, 1);
    check({tag, "_ack_waddr"}, dpram_addr, 127);
    check({tag, "_cmds"}, rq_addr.size() - rb, 128);
    if (rq_addr.size() - rb == 128) begin
      for (int k = 0; k < 128; k++) begin
        if (rq_addr[rb + k] !== 28'(base + 28'(8 * k))) bad++;
      end
      check({tag, "_cmd_addr"}, bad, 0);
    end
    pg_req = 1'b0;
    @(negedge clk);
    check({tag, "_ack_drop"}, pg_ack, 0);
    check({tag, "_wren_pulses"}, wren_cnt - wb, 128);
    bad = 0;
    for (int k = 0; k < 128; k++) begin
      if (mem[k] !== rd_pat(rb + k)) bad++;
    end
    check({tag, "_dpram_data"}, bad, 0);
    check({tag, "_dpram_w0"}, mem[0], rd_pat(rb));
  endtask

  initial begin
    int c0, at, wb, rb, w0, e0, a0, p0, n;
    rst = 1'b1;
    pg_req = 1'b0;
    pg_optype = 1'b0;
    pg_req_addr = '0;
    init_calib_complete = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);

    // Write, MIG always ready
    mode = 0;
    wb = wq_addr.size();
    pg_optype = 1'b1;
    pg_req_addr = 28'h0001000;
    pg_req = 1'b1;
    c0 = cyc;
    wait_ack(600, at);
    check("wr_ack_latency", at - (c0 + 1), 256);
    check_writes("wr", wb, 28'h0001000);
    check("wr_pairing", viol, 0);
    pg_req = 1'b0;
    @(negedge clk);
    check("wr_ack_drop", pg_ack, 0);

    // Write with wdf_rdy stalls on beats 3-5 and app_rdy stall on beat 10
    mode = 1;
    wr_base = acc_cnt;
    wb = wq_addr.size();
    pg_req_addr = 28'h0200000;
    pg_req = 1'b1;
    c0 = cyc;
    wait_ack(800, at);
    check("wrs_ack_latency", at - (c0 + 1), 264);
    check_writes("wrs", wb, 28'h0200000);
    check("wrs_pairing", viol, 0);

    // Hold pg_req after ack, then a one-cycle low and an immediate read request
    repeat (5) begin
      @(negedge clk);
      check("b2b_ack_held", pg_ack, 1);
    end
    mode = 2;
    pg_req = 1'b0;
    @(negedge clk);
    check("b2b_ack_low", pg_ack, 0);
    check("b2b_no_en", app_en, 0);
    pg_optype = 1'b0;
    pg_req_addr = 28'hFFFFFC0;
    pg_req = 1'b1;
    rb = rq_addr.size();
    w0 = wren_cnt;
    @(negedge clk);
    check("rd_start_en", app_en, 1);
    check("rd_start_cmd", app_cmd, 3'b001);
    check("rd_start_addr", app_addr, 28'hFFFFFC0);
    wait_ack(3000, at);
    if (rq_addr.size() - rb > 8) check("rd_wrap_addr", rq_addr[rb + 8], 28'h0000000);
    finish_read("rd", rb, w0, 28'hFFFFFC0);

    // Request while uncalibrated
    init_calib_complete = 1'b0;
    pg_optype = 1'b0;
    pg_req_addr = 28'h0000100;
    pg_req = 1'b1;
    e0 = en_cnt;
    a0 = ack_cnt;
    repeat (50) @(negedge clk);
    check("cal_no_en", en_cnt - e0, 0);
    check("cal_no_ack", ack_cnt - a0, 0);
    rb = rq_addr.size();
    w0 = wren_cnt;
    init_calib_complete = 1'b1;
    @(negedge clk);
    check("cal_start_en", app_en, 1);
    check("cal_start_addr", app_addr, 28'h0000100);
    wait_ack(3000, at);
    finish_read("cal", rb, w0, 28'h0000100);

    // Reset at beat 60 of a read, then late returns must be ignored
    pg_req_addr = 28'h0300000;
    pg_req = 1'b1;
    w0 = wren_cnt;
    n = 0;
    while (wren_cnt - w0 < 60 && n < 2000) begin
      @(negedge clk);
      n++;
    end
    check("rr_reached_60", (wren_cnt - w0 >= 60), 1);
    rst = 1'b1;
    pg_req = 1'b0;
    @(negedge clk);
    check_reset_outputs("rr");
    rst = 1'b0;
    w0 = wren_cnt;
    a0 = ack_cnt;
    e0 = en_cnt;
    p0 = ret_ptr;
    repeat (200) @(negedge clk);
    check("rr_strays_sent", (ret_ptr > p0), 1);
    check("rr_no_wren", wren_cnt - w0, 0);
    check("rr_no_ack", ack_cnt - a0, 0);
    check("rr_no_en", en_cnt - e0, 0);
    check("rr_dpram_addr", dpram_addr, 0);

    // Normal read after the abandoned one
    rb = rq_addr.size();
    w0 = wren_cnt;
    pg_req_addr = 28'h0000000;
    pg_req = 1'b1;
    wait_ack(3000, at);
    finish_read("rr2", rb, w0, 28'h0000000);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, expected completion before 200000");
    $fatal(1);
  end

endmodule

// File: doc/ddr3_pg_transfer_engine.md
# ddr3_pg_transfer_engine

Responder end of the DDR3 page-transfer handshake. Accepts one page request at a time from the page-transfer mux and moves one page between the shared page DPRAM and DDR3 through the MIG user interface. Optype 1 writes DPRAM→DDR3; optype 0 reads DDR3→DPRAM. Runs in the DDR3 ui clock domain, so pg_req arrives already synchronized.

## Interface
- P_PG_BEATS, 128: 128-bit UI words per page (power of 2).
- P_ADDR_STEP, 8: app_addr increment per beat.
- clk  in  1  DDR3 ui clock.
- rst  in  1  reset, synchronous, active-high.
- pg_req  in  1  page request; held high until pg_ack seen.
- pg_optype  in  1  1 = write DDR3, 0 = read DDR3.
- pg_req_addr  in  28  page start address (MIG app_addr units).
- pg_ack  out  1  transfer complete; held until pg_req low.
- dpram_addr  out  log2(P_PG_BEATS)  DPRAM word address (read addr in write op, write addr in read op).
- dpram_dout  in  128  DPRAM read data, 1-cycle registered latency.
- dpram_din  out  128  DPRAM write data.
- dpram_wren  out  1  DPRAM write strobe.
- init_calib_complete  in  1  MIG calibration done.
- app_addr  out  28; app_cmd  out  3 (000 write, 001 read); app_en  out  1; app_rdy  in  1.
- app_wdf_data  out  128; app_wdf_wren  out  1; app_wdf_end  out  1; app_wdf_mask  out  16 (constant 0); app_wdf_rdy  in  1.
- app_rd_data  in  128; app_rd_data_valid  in  1.

## Operation
- States: S_IDLE, S_WR_FETCH, S_WR_ISSUE, S_RD, S_ACK.
- S_IDLE: when pg_req && init_calib_complete: latch pg_req_addr into app_addr, latch optype, clear beat/cmd/return counters, dpram_addr←0; go to S_WR_FETCH (optype 1) or S_RD (optype 0). pg_req while uncalibrated: wait, no ack.
- S_WR_FETCH: one cycle; dpram_addr stable, DPRAM output becomes valid. → S_WR_ISSUE.
- S_WR_ISSUE: app_cmd=000, app_wdf_data=dpram_dout, app_wdf_end=app_wdf_wren. app_en = app_wdf_rdy; app_wdf_wren = app_rdy (combinational, so command and data accepted in the same cycle only). Beat accepted when app_rdy && app_wdf_rdy. On accept: last beat → S_ACK; else app_addr += P_ADDR_STEP, dpram_addr += 1, → S_WR_FETCH. dpram_addr held constant throughout S_WR_ISSUE.
- S_RD: app_cmd=001; app_en=1 while cmd count < P_PG_BEATS. Each app_en && app_rdy: cmd count += 1, app_addr += P_ADDR_STEP. Independently, each app_rd_data_valid: register dpram_din←app_rd_data, dpram_wren←1, dpram_addr←return count, return count += 1. MIG returns in order. After the P_PG_BEATS-th return is registered → S_ACK (the final dpram_wren pulse occurs on the S_RD→S_ACK edge).
- S_ACK: pg_ack=1. When pg_req low: pg_ack←0 next cycle, → S_IDLE. New request not accepted until pg_ack is low.
- app_rd_data_valid outside S_RD: ignored, no dpram_wren.
- app_addr arithmetic modulo 2^28 (wraps silently). Counters width log2(P_PG_BEATS)+1.
- pg_optype / pg_req_addr sampled only at acceptance; later changes ignored.

## Timing
- Reset values: pg_ack 0, app_en 0, app_wdf_wren 0, app_wdf_end 0, dpram_wren 0, dpram_addr 0, app_addr 0, app_cmd 000, dpram_din 0, state S_IDLE.
- Reset mid-transfer: abandon immediately, all outputs to reset values next cycle; no ack; late MIG read returns ignored.
- Accept latency: pg_req high in S_IDLE at edge N → first app_en/wren eligible cycle N+2 (write), N+1 (read).
- Write throughput: 2 cycles/beat minimum; 128 beats with MIG always ready = 256 cycles, pg_ack high the cycle after last accept.
- Read throughput: 1 command/cycle while app_rdy; ack one cycle after last return registered.
- pg_ack deasserts exactly 1 cycle after pg_req sampled low.
- dpram_wren is a single-cycle pulse per returned beat, 1 cycle after app_rd_data_valid.

## Test plan
- Write, MIG always ready, addr 0x0001000, DPRAM word k = k: 128 write beats at app_addr 0x1000+8k with data k, pg_ack after 256 cycles, drops 1 cycle after pg_req low.
- Write with app_wdf_rdy low on beats 3–5 and app_rdy low on beat 10: no command without matching data, each beat exactly once, order preserved.
- Read addr 0xFFFFFC0, rd_data returned with 20-cycle latency and random gaps: app_addr wraps to 0x0000000 after 8 cmds; DPRAM word k = returned beat k; 128 dpram_wren pulses; ack after last.
- pg_req high with init_calib_complete low for 50 cycles: no app_en, no ack; transfer starts 1 cycle after calibration.
- rst asserted at beat 60 of a read, then stray app_rd_data_valid: all outputs reset, no dpram_wren, no ack; next request completes normally.
- Back-to-back: pg_req held 5 cycles after ack then new request with optype flipped: second transfer starts only after pg_ack low.
